// File: rtl/synch_fifo_prog.sv
// rtl/synch_fifo_prog.sv - synchronous FIFO with fill level, programmable almost flags and FWFT mode
module synch_fifo_prog #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    rd_en_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW:0] L_AF    = (PW+1)'(AF_THRESH);
  localparam logic [PW:0] L_AE    = (PW+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]           r_wr_ptr;
  logic [PW:0]           r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [PW:0]           w_count;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  // Occupancy comes straight from the registered pointers; the wrap bit
  // separates full (difference DEPTH) from empty (difference 0).
  assign w_count        = r_wr_ptr - r_rd_ptr;
  assign count_o        = w_count;
  assign full_o         = (w_count == L_DEPTH);
  assign empty_o        = (w_count == '0);
  assign almost_full_o  = (w_count >= L_AF);
  assign almost_empty_o = (w_count <= L_AE);
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

  assign w_rd_acc = rd_en_i && !empty_o;
  assign w_wr_acc = wr_en_i && (!full_o || w_rd_acc);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[PW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow  <= wr_en_i && !w_wr_acc;
      r_underflow <= rd_en_i && !w_rd_acc;
    end
  end

  if (FWFT != 0) begin : g_fwft
    logic [DATA_WIDTH-1:0] r_last;

    // Tracks the head while one exists so the last popped word stays visible.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_last <= '0;
      end else if (!empty_o) begin
        r_last <= r_mem[r_rd_ptr[PW-1:0]];
      end
    end

    assign rdata_o  = empty_o ? r_last : r_mem[r_rd_ptr[PW-1:0]];
    assign rvalid_o = !empty_o;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        if (w_rd_acc) r_rdata <= r_mem[r_rd_ptr[PW-1:0]];
        r_rvalid <= w_rd_acc;
      end
    end

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;
  end

endmodule

// File: tb/tb_synch_fifo_prog.sv
// tb/tb_synch_fifo_prog.sv - directed self-checking bench for synch_fifo_prog
module tb_synch_fifo_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, full, empty, afull, aempty, ovf, unf;
  logic [4:0] count;

  logic       f_wr = 1'b0;
  logic [7:0] f_wdata = 8'h00;
  logic       f_rd = 1'b0;
  logic [7:0] f_rdata;
  logic       f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [4:0] f_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  synch_fifo_prog #(.DEPTH(16), .DATA_WIDTH(8), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
    .rdata_o(rdata), .rvalid_o(rvalid), .full_o(full), .empty_o(empty),
    .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
    .overflow_o(ovf), .underflow_o(unf)
  );

  synch_fifo_prog #(.DEPTH(16), .DATA_WIDTH(8), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en_i(f_wr), .wdata_i(f_wdata), .rd_en_i(f_rd),
    .rdata_o(f_rdata), .rvalid_o(f_rvalid), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_afull), .almost_empty_o(f_aempty), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    wr_en = wr;
    wdata = d;
    rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_aempty", 32'(aempty), 1);
    check("rst_afull", 32'(afull), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_unf", 32'(unf), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_f_rvalid", 32'(f_rvalid), 0);
    check("rst_f_rdata", 32'(f_rdata), 0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      check("fill_count", 32'(count), 32'(i));
      check("fill_empty", 32'(empty), 0);
      check("fill_afull", 32'(afull), 32'(i >= 14));
      check("fill_full", 32'(full), 32'(i == 16));
      check("fill_aempty", 32'(aempty), 32'(i <= 2));
    end

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hEE, 1'b0);
      check("ovf_pulse", 32'(ovf), 1);
      check("ovf_count", 32'(count), 16);
    end
    step(1'b0, 8'h00, 1'b0);
    check("ovf_clear", 32'(ovf), 0);

    // Full with simultaneous write+read: pops 0x01..0x05, pushes 0x11..0x15
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(16 + i), 1'b1);
      check("fullrw_rdata", 32'(rdata), 32'(i));
      check("fullrw_rvalid", 32'(rvalid), 1);
      check("fullrw_count", 32'(count), 16);
      check("fullrw_ovf", 32'(ovf), 0);
    end

    // Drain: 0x06..0x15 in order
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("drain_rdata", 32'(rdata), 32'(5 + i));
      check("drain_rvalid", 32'(rvalid), 1);
      check("drain_count", 32'(count), 32'(16 - i));
      check("drain_aempty", 32'(aempty), 32'((16 - i) <= 2));
      check("drain_empty", 32'(empty), 32'(i == 16));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("unf_pulse", 32'(unf), 1);
      check("unf_rvalid", 32'(rvalid), 0);
      check("unf_rdata_hold", 32'(rdata), 32'h15);
    end
    step(1'b0, 8'h00, 1'b0);
    check("unf_clear", 32'(unf), 0);

    // Empty with simultaneous write+read
    step(1'b1, 8'h77, 1'b1);
    check("emptyrw_count", 32'(count), 1);
    check("emptyrw_unf", 32'(unf), 1);
    check("emptyrw_rvalid", 32'(rvalid), 0);
    step(1'b0, 8'h00, 1'b1);
    check("emptyrw_rdata", 32'(rdata), 32'h77);
    check("emptyrw_count2", 32'(count), 0);
    check("emptyrw_unf2", 32'(unf), 0);

    // Wrap-around: 4 rounds of 10 writes then 10 reads
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 8'(r * 16 + i + 8'h40), 1'b0);
      check("wrap_count_full", 32'(count), 10);
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 8'h00, 1'b1);
        check("wrap_rdata", 32'(rdata), 32'(r * 16 + i + 8'h40));
      end
      check("wrap_empty", 32'(empty), 1);
      check("wrap_full", 32'(full), 0);
    end
    step(1'b0, 8'h00, 1'b0);

    // Mid-burst asynchronous reset at count 7
    for (int i = 0; i < 7; i++) step(1'b1, 8'(i), 1'b0);
    check("mid_count", 32'(count), 7);
    wr_en = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_aempty", 32'(aempty), 1);
    check("arst_afull", 32'(afull), 0);
    check("arst_full", 32'(full), 0);
    check("arst_rvalid", 32'(rvalid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // FWFT instance: head word visible without a read
    f_wr = 1'b1;
    f_wdata = 8'hA5;
    @(posedge clk);
    #1;
    f_wr = 1'b0;
    check("fwft_empty", 32'(f_empty), 0);
    check("fwft_rvalid", 32'(f_rvalid), 1);
    check("fwft_rdata", 32'(f_rdata), 32'hA5);
    f_rd = 1'b1;
    @(posedge clk);
    #1;
    f_rd = 1'b0;
    check("fwft_pop_empty", 32'(f_empty), 1);
    check("fwft_pop_rvalid", 32'(f_rvalid), 0);
    check("fwft_pop_hold", 32'(f_rdata), 32'hA5);
    check("fwft_pop_unf", 32'(f_unf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
